// File: rtl/rl_force_accumulator_if.sv
// Force-stream bus between the pair evaluator and the force accumulator.
// The master side drives pair forces and particle closes; the slave side
// returns the summed vector, its particle index and status flags.
interface rl_force_accumulator_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 8
) ();
  logic                  in_force_valid;
  logic [DATA_WIDTH-1:0] in_Force_X;
  logic [DATA_WIDTH-1:0] in_Force_Y;
  logic [DATA_WIDTH-1:0] in_Force_Z;
  logic                  particle_done;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_Force_X;
  logic [DATA_WIDTH-1:0] out_Force_Y;
  logic [DATA_WIDTH-1:0] out_Force_Z;
  logic [ID_WIDTH-1:0]   out_particle_id;
  logic                  busy;
  logic                  overflow_err;

  modport master (
    output in_force_valid, in_Force_X, in_Force_Y, in_Force_Z, particle_done,
    input  out_valid, out_Force_X, out_Force_Y, out_Force_Z, out_particle_id,
           busy, overflow_err
  );

  modport slave (
    input  in_force_valid, in_Force_X, in_Force_Y, in_Force_Z, particle_done,
    output out_valid, out_Force_X, out_Force_Y, out_Force_Z, out_particle_id,
           busy, overflow_err
  );
endinterface

// File: rtl/rl_force_accumulator.sv
// Per-particle force accumulator: three interleaved partial-sum lanes per
// axis hide the two-cycle float adder, then a short reduction folds the
// lanes into one vector that is emitted once per reference particle.

// Two-stage IEEE-754 single adder: round-to-nearest-even, denormals
// flushed to zero, NaN and Inf operands passed through unmodified.
module rl_fp_add (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum
);
  logic        sa, sb;
  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  logic        swap, sub, big_s;
  logic [7:0]  big_e, small_e, diff;
  logic [23:0] big_m, small_m;
  logic [49:0] shifted;
  logic [26:0] big_x, small_x;
  logic [27:0] raw_d;
  logic        bypass_d;
  logic [31:0] bypass_val_d;

  logic        s1_bypass;
  logic [31:0] s1_bypass_val;
  logic        s1_sign;
  logic [7:0]  s1_exp;
  logic [27:0] s1_raw;

  int          lz;
  int          exp_n;
  logic [26:0] norm;
  logic        round_up;
  logic [24:0] mant;
  logic [22:0] frac;
  logic [31:0] result;

  assign {sa, ea, fa} = a;
  assign {sb, eb, fb} = b;
  assign a_zero = (ea == 8'd0);
  assign b_zero = (eb == 8'd0);
  assign a_inf  = (ea == 8'hFF) && (fa == 23'd0);
  assign b_inf  = (eb == 8'hFF) && (fb == 23'd0);
  assign a_nan  = (ea == 8'hFF) && (fa != 23'd0);
  assign b_nan  = (eb == 8'hFF) && (fb != 23'd0);

  // Stage 1: order by magnitude, align the smaller operand with guard/round/sticky, add or subtract
  always_comb begin
    swap    = {ea, fa} < {eb, fb};
    sub     = sa ^ sb;
    big_s   = swap ? sb : sa;
    big_e   = swap ? eb : ea;
    small_e = swap ? ea : eb;
    big_m   = swap ? {1'b1, fb} : {1'b1, fa};
    small_m = swap ? {1'b1, fa} : {1'b1, fb};
    diff    = big_e - small_e;
    shifted = {small_m, 26'd0} >> diff;
    if (diff > 8'd26) begin
      small_x = {26'd0, 1'b1};
    end else begin
      small_x = {shifted[49:24], |shifted[23:0]};
    end
    big_x = {big_m, 3'b000};
    if (sub) begin
      raw_d = {1'b0, big_x} - {1'b0, small_x};
    end else begin
      raw_d = {1'b0, big_x} + {1'b0, small_x};
    end
    bypass_d     = 1'b1;
    bypass_val_d = 32'h0000_0000;
    if (a_nan) begin
      bypass_val_d = a;
    end else if (b_nan) begin
      bypass_val_d = b;
    end else if (a_inf && b_inf && sub) begin
      bypass_val_d = 32'h7FC0_0000;
    end else if (a_inf) begin
      bypass_val_d = a;
    end else if (b_inf) begin
      bypass_val_d = b;
    end else if (a_zero && b_zero) begin
      bypass_val_d = {sa & sb, 31'd0};
    end else if (a_zero) begin
      bypass_val_d = b;
    end else if (b_zero) begin
      bypass_val_d = a;
    end else begin
      bypass_d = 1'b0;
    end
  end

  // Stage 1 pipeline register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_bypass     <= 1'b0;
      s1_bypass_val <= 32'h0000_0000;
      s1_sign       <= 1'b0;
      s1_exp        <= 8'd0;
      s1_raw        <= 28'd0;
    end else begin
      s1_bypass     <= bypass_d;
      s1_bypass_val <= bypass_val_d;
      s1_sign       <= big_s;
      s1_exp        <= big_e;
      s1_raw        <= raw_d;
    end
  end

  // Stage 2: normalise, round to nearest even, flush underflow, saturate overflow to Inf
  always_comb begin
    lz = 27;
    for (int i = 0; i < 27; i++) begin
      if (s1_raw[i]) lz = 26 - i;
    end
    if (s1_raw[27]) begin
      norm  = {s1_raw[27:2], s1_raw[1] | s1_raw[0]};
      exp_n = int'(s1_exp) + 1;
    end else begin
      norm  = s1_raw[26:0] << lz;
      exp_n = int'(s1_exp) - lz;
    end
    round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    mant     = {1'b0, norm[26:3]} + {24'd0, round_up};
    if (mant[24]) begin
      frac  = mant[23:1];
      exp_n = exp_n + 1;
    end else begin
      frac = mant[22:0];
    end
    if (s1_bypass) begin
      result = s1_bypass_val;
    end else if (s1_raw == 28'd0) begin
      result = 32'h0000_0000;
    end else if (exp_n <= 0) begin
      result = {s1_sign, 31'd0};
    end else if (exp_n >= 255) begin
      result = {s1_sign, 8'hFF, 23'd0};
    end else begin
      result = {s1_sign, exp_n[7:0], frac};
    end
  end

  // Stage 2 result register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum <= 32'h0000_0000;
    end else begin
      sum <= result;
    end
  end
endmodule

module rl_force_accumulator #(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  rl_force_accumulator_if.slave bus
);
  typedef enum logic [2:0] {ACCUM, DRAIN, SUM01, SUM2, EMIT} state_t;

  state_t                state, state_next;
  logic                  step, step_next;
  logic                  accept;
  logic                  busy_c;
  logic [1:0]            ptr;
  logic                  wb1_valid, wb2_valid;
  logic [1:0]            wb1_lane, wb2_lane;
  logic [DATA_WIDTH-1:0] lane      [3][3];
  logic [DATA_WIDTH-1:0] force_in  [3];
  logic [DATA_WIDTH-1:0] op_a      [3];
  logic [DATA_WIDTH-1:0] op_b      [3];
  logic [DATA_WIDTH-1:0] add_sum   [3];
  logic [DATA_WIDTH-1:0] out_force [3];
  logic                  out_valid_r;
  logic [ID_WIDTH-1:0]   particle_id;
  logic                  overflow_r;

  assign force_in[0] = bus.in_Force_X;
  assign force_in[1] = bus.in_Force_Y;
  assign force_in[2] = bus.in_Force_Z;

  assign bus.out_valid       = out_valid_r;
  assign bus.out_Force_X     = out_force[0];
  assign bus.out_Force_Y     = out_force[1];
  assign bus.out_Force_Z     = out_force[2];
  assign bus.out_particle_id = particle_id;
  assign bus.busy            = busy_c;
  assign bus.overflow_err    = overflow_r;

  // FSM state register; step marks the second cycle of the two-cycle states
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ACCUM;
      step  <= 1'b0;
    end else begin
      state <= state_next;
      step  <= step_next;
    end
  end

  // Next state: accumulate until done, then drain, reduce in two adds and emit
  always_comb begin
    state_next = state;
    step_next  = 1'b0;
    accept     = 1'b0;
    busy_c     = (state != ACCUM);
    case (state)
      ACCUM: begin
        accept = bus.in_force_valid;
        if (bus.particle_done) state_next = DRAIN;
      end
      DRAIN: begin
        if (step) state_next = SUM01;
        else      step_next  = 1'b1;
      end
      SUM01: begin
        if (step) state_next = SUM2;
        else      step_next  = 1'b1;
      end
      SUM2: begin
        if (step) state_next = EMIT;
        else      step_next  = 1'b1;
      end
      EMIT:    state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  // Adder operands: lane plus incoming force while accumulating, lane pairs while reducing
  always_comb begin
    for (int ax = 0; ax < 3; ax++) begin
      op_a[ax] = lane[ax][0];
      op_b[ax] = force_in[ax];
      case (state)
        SUM01: begin
          op_a[ax] = lane[ax][0];
          op_b[ax] = lane[ax][1];
        end
        SUM2: begin
          op_a[ax] = add_sum[ax];
          op_b[ax] = lane[ax][2];
        end
        default: begin
          case (ptr)
            2'd1:    op_a[ax] = lane[ax][1];
            2'd2:    op_a[ax] = lane[ax][2];
            default: op_a[ax] = lane[ax][0];
          endcase
        end
      endcase
    end
  end

  for (genvar ax = 0; ax < 3; ax++) begin : g_axis
    rl_fp_add u_add (
      .clk (clk),
      .rst (rst),
      .a   (op_a[ax]),
      .b   (op_b[ax]),
      .sum (add_sum[ax])
    );
  end

  // Mod-3 lane pointer advances per accepted force and restarts with each particle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= 2'd0;
    end else if (state == EMIT) begin
      ptr <= 2'd0;
    end else if (accept) begin
      ptr <= (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
    end
  end

  // Track which lane each in-flight add belongs to, aligned with the adder latency
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb1_valid <= 1'b0;
      wb1_lane  <= 2'd0;
      wb2_valid <= 1'b0;
      wb2_lane  <= 2'd0;
    end else begin
      wb1_valid <= accept;
      wb1_lane  <= ptr;
      wb2_valid <= wb1_valid;
      wb2_lane  <= wb1_lane;
    end
  end

  // Partial-sum lanes: write back retired adds, clear when a particle is emitted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int ax = 0; ax < 3; ax++)
        for (int l = 0; l < 3; l++) lane[ax][l] <= '0;
    end else if (state == EMIT) begin
      for (int ax = 0; ax < 3; ax++)
        for (int l = 0; l < 3; l++) lane[ax][l] <= '0;
    end else if (wb2_valid) begin
      for (int ax = 0; ax < 3; ax++)
        for (int l = 0; l < 3; l++)
          if (wb2_lane == 2'(l)) lane[ax][l] <= add_sum[ax];
    end
  end

  // Output vector, one-cycle valid pulse and particle counter bumped after each pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_r <= 1'b0;
      particle_id <= '0;
      for (int ax = 0; ax < 3; ax++) out_force[ax] <= '0;
    end else begin
      out_valid_r <= (state == EMIT);
      if (state == EMIT) begin
        for (int ax = 0; ax < 3; ax++) out_force[ax] <= add_sum[ax];
      end
      if (out_valid_r) particle_id <= particle_id + ID_WIDTH'(1);
    end
  end

  // Sticky flag for any force or close that arrives while the block is busy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_r <= 1'b0;
    end else if (busy_c && (bus.in_force_valid || bus.particle_done)) begin
      overflow_r <= 1'b1;
    end
  end
endmodule

// File: tb/tb_rl_force_accumulator.sv
// Scoreboard bench for rl_force_accumulator: directed and random particles,
// expected vectors computed as exact quarter-unit integer sums.
module tb_rl_force_accumulator;
  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] z;
    logic [7:0]  id;
    int          cycle;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cycle_count = 0;
  int   compared = 0;
  int   mismatched = 0;
  exp_t exp_q[$];
  logic [7:0] exp_id = 8'd0;

  logic [31:0] stim_x[$];
  logic [31:0] stim_y[$];
  logic [31:0] stim_z[$];
  int          stim_gap[$];

  rl_force_accumulator_if #(.DATA_WIDTH(32), .ID_WIDTH(8)) bus ();

  rl_force_accumulator #(.DATA_WIDTH(32), .ID_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle_count <= cycle_count + 1;

  // Exact single-precision encoding of q/4 for |q| < 2^24
  function automatic logic [31:0] quarters_to_float(input int q);
    logic [31:0] mag;
    int          msb;
    logic [31:0] shifted;
    if (q == 0) return 32'h0000_0000;
    mag = (q < 0) ? -q : q;
    msb = 0;
    for (int i = 0; i < 32; i++) if (mag[i]) msb = i;
    shifted = mag << (23 - msb);
    return {q < 0, 8'(msb + 125), shifted[22:0]};
  endfunction

  task automatic check_value(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    check_value($sformatf("p%0d_x", e.id), bus.out_Force_X, e.x);
    check_value($sformatf("p%0d_y", e.id), bus.out_Force_Y, e.y);
    check_value($sformatf("p%0d_z", e.id), bus.out_Force_Z, e.z);
    check_value($sformatf("p%0d_id", e.id), {24'd0, bus.out_particle_id}, {24'd0, e.id});
    check_value($sformatf("p%0d_cycle", e.id), cycle_count, e.cycle);
  endtask

  // Monitor: every out_valid pulse is matched against the oldest expected vector
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected_out_valid: got 1 at cycle %0d, required 0", cycle_count);
        end else begin
          e = exp_q.pop_front();
          checkOutput(e);
        end
      end
    end
  end

  task automatic drive_cycle(input logic v, input logic [31:0] x, input logic [31:0] y,
                             input logic [31:0] z, input logic done);
    @(posedge clk);
    #1;
    bus.in_force_valid = v;
    bus.in_Force_X     = x;
    bus.in_Force_Y     = y;
    bus.in_Force_Z     = z;
    bus.particle_done  = done;
  endtask

  task automatic drive_idle();
    drive_cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
  endtask

  // Drives the queued forces, closes the particle, pushes its expected vector
  // and idles through the busy window, optionally poking input at drain cycle intrude_at.
  task automatic applyStimulus(input int done_delay, input int intrude_at,
                               input logic [31:0] ex, input logic [31:0] ey, input logic [31:0] ez);
    int   d;
    logic last;
    exp_t e;
    d = 0;
    for (int i = 0; i < stim_x.size(); i++) begin
      repeat (stim_gap[i]) drive_idle();
      last = (i == stim_x.size() - 1) && (done_delay == 0);
      drive_cycle(1'b1, stim_x[i], stim_y[i], stim_z[i], last);
      if (last) d = cycle_count;
    end
    if (stim_x.size() == 0 || done_delay > 0) begin
      if (stim_x.size() != 0) repeat (done_delay - 1) drive_idle();
      drive_cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
      d = cycle_count;
    end
    e.x = ex; e.y = ey; e.z = ez; e.id = exp_id; e.cycle = d + 8;
    exp_q.push_back(e);
    exp_id = exp_id + 8'd1;
    for (int k = 1; k <= 7; k++) begin
      if (intrude_at != 0 && k == intrude_at)
        drive_cycle(1'b1, 32'h42C8_0000, 32'h42C8_0000, 32'h42C8_0000, 1'b0);
      else if (intrude_at != 0 && k == intrude_at + 2)
        drive_cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
      else
        drive_idle();
      check_value("busy_window", {31'd0, bus.busy}, 32'd1);
    end
    stim_x.delete(); stim_y.delete(); stim_z.delete(); stim_gap.delete();
  endtask

  task automatic add_force(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z, input int gap);
    stim_x.push_back(x); stim_y.push_back(y); stim_z.push_back(z); stim_gap.push_back(gap);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) drive_idle();
    check_value("drain_timeout", exp_q.size(), 32'd0);
  endtask

  task automatic random_particle(input int max_forces);
    int n, qx, qy, qz, sx, sy, sz;
    sx = 0; sy = 0; sz = 0;
    n = $urandom_range(0, max_forces);
    for (int i = 0; i < n; i++) begin
      qx = int'($urandom_range(0, 800)) - 400;
      qy = int'($urandom_range(0, 800)) - 400;
      qz = int'($urandom_range(0, 800)) - 400;
      sx += qx; sy += qy; sz += qz;
      add_force(quarters_to_float(qx), quarters_to_float(qy), quarters_to_float(qz),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0);
    end
    applyStimulus($urandom_range(0, 2), 0,
                  quarters_to_float(sx), quarters_to_float(sy), quarters_to_float(sz));
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cycle_count);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.in_force_valid = 1'b0;
    bus.in_Force_X     = 32'h0;
    bus.in_Force_Y     = 32'h0;
    bus.in_Force_Z     = 32'h0;
    bus.particle_done  = 1'b0;

    // Reset held with random inputs: outputs must stay at reset values
    for (int i = 0; i < 6; i++) begin
      drive_cycle(1'($urandom_range(0, 1)), $urandom(), $urandom(), $urandom(), 1'($urandom_range(0, 1)));
      @(negedge clk);
      check_value("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check_value("rst_busy", {31'd0, bus.busy}, 32'd0);
      check_value("rst_overflow", {31'd0, bus.overflow_err}, 32'd0);
      check_value("rst_x", bus.out_Force_X, 32'h0);
      check_value("rst_id", {24'd0, bus.out_particle_id}, 32'd0);
    end
    rst = 1'b1;
    drive_idle();
    check_value("idle_busy", {31'd0, bus.busy}, 32'd0);
    check_value("idle_overflow", {31'd0, bus.overflow_err}, 32'd0);

    // Single particle with done on the third force
    add_force(32'h3F80_0000, 32'h4000_0000, 32'h4080_0000, 0);
    add_force(32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 0);
    add_force(32'h4080_0000, 32'h4000_0000, 32'h4080_0000, 0);
    applyStimulus(0, 0, 32'h40E0_0000, 32'h40C0_0000, 32'h4140_0000);

    // Lane stress: 7, 1, 2 and 3 forces of 1.0 with done one cycle after the last
    for (int i = 0; i < 7; i++) add_force(32'h3F80_0000, 32'h0, 32'h0, 0);
    applyStimulus(1, 0, 32'h40E0_0000, 32'h0, 32'h0);
    add_force(32'h3F80_0000, 32'h0, 32'h0, 0);
    applyStimulus(1, 0, 32'h3F80_0000, 32'h0, 32'h0);
    for (int i = 0; i < 2; i++) add_force(32'h3F80_0000, 32'h0, 32'h0, 0);
    applyStimulus(1, 0, 32'h4000_0000, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) add_force(32'h3F80_0000, 32'h0, 32'h0, 0);
    applyStimulus(1, 0, 32'h4040_0000, 32'h0, 32'h0);

    // Empty particle, then the counter must have moved on by one
    applyStimulus(0, 0, 32'h0, 32'h0, 32'h0);
    drive_idle();
    drive_idle();
    check_value("id_after_empty", {24'd0, bus.out_particle_id}, {24'd0, exp_id});

    // Force and close arriving during the drain are dropped and flagged
    add_force(32'h4040_0000, 32'hBF80_0000, 32'h3E80_0000, 0);
    add_force(32'h3F80_0000, 32'hBF80_0000, 32'h3E80_0000, 1);
    applyStimulus(0, 3, 32'h4080_0000, 32'hC000_0000, 32'h3F00_0000);
    check_value("overflow_set", {31'd0, bus.overflow_err}, 32'd1);
    add_force(32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 0);
    add_force(32'h4000_0000, 32'h4000_0000, 32'hC000_0000, 0);
    applyStimulus(1, 0, 32'h4080_0000, 32'h4080_0000, 32'h0);
    check_value("overflow_sticky", {31'd0, bus.overflow_err}, 32'd1);

    // Randomised particles against the exact-sum model
    for (int p = 0; p < 24; p++) random_particle(10);

    // Enough particles for the 8-bit counter to wrap
    for (int p = 0; p < 256; p++) random_particle(1);
    wait_drain();

    // Reset during the first reduction add: nothing emitted, outputs cleared
    add_force(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 0);
    add_force(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 0);
    drive_cycle(1'b1, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 1'b0);
    drive_cycle(1'b1, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 1'b1);
    stim_x.delete(); stim_y.delete(); stim_z.delete(); stim_gap.delete();
    repeat (3) drive_idle();
    check_value("busy_before_reset", {31'd0, bus.busy}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check_value("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check_value("midrst_busy", {31'd0, bus.busy}, 32'd0);
    check_value("midrst_overflow", {31'd0, bus.overflow_err}, 32'd0);
    check_value("midrst_x", bus.out_Force_X, 32'h0);
    check_value("midrst_y", bus.out_Force_Y, 32'h0);
    check_value("midrst_z", bus.out_Force_Z, 32'h0);
    check_value("midrst_id", {24'd0, bus.out_particle_id}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (12) drive_idle();
    exp_id = 8'd0;

    // First particle after the abort starts from clean lanes and index 0
    add_force(32'h4000_0000, 32'h3F80_0000, 32'h4080_0000, 0);
    add_force(32'h3F80_0000, 32'h3F80_0000, 32'h4080_0000, 0);
    applyStimulus(0, 0, 32'h4040_0000, 32'h4000_0000, 32'h4100_0000);
    wait_drain();
    repeat (3) drive_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
